// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port 16-bit byte-writable RAM.
// Round-robin on conflict, with a starvation-bounded burst lock for port 1.
module ram_port_arbiter #(
    parameter int P_LOCK_MAX = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_wr0,
    input  logic       i_wr1,
    input  logic [1:0] i_be0,
    input  logic [1:0] i_be1,
    input  logic [9:1] i_addr0,
    input  logic [9:1] i_addr1,
    input  logic [15:0] i_wdata0,
    input  logic [15:0] i_wdata1,
    input  logic       i_lock1,
    output logic       o_gnt0,
    output logic       o_gnt1,
    output logic       o_rvalid0,
    output logic       o_rvalid1,
    output logic [15:0] o_rdata,
    output logic       o_mem_en,
    output logic       o_mem_we_h,
    output logic       o_mem_we_l,
    output logic [9:1] o_mem_addr,
    output logic [7:0] o_mem_din_h,
    output logic [7:0] o_mem_din_l,
    input  logic [7:0] i_mem_dout_h,
    input  logic [7:0] i_mem_dout_l
);

    localparam int CW = $clog2(P_LOCK_MAX + 1);
    localparam logic [CW-1:0] LMAX = CW'(P_LOCK_MAX);

    // last_q: 1 means requester 1 was granted most recently
    logic          last_q, last_d;
    logic          lock_q, lock_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rv0_q, rv0_d;
    logic          rv1_q, rv1_d;

    logic lock_act;
    logic cnt_hit;
    logic gnt0, gnt1;

    assign lock_act = lock_q & i_req1 & i_lock1;
    assign cnt_hit  = (cnt_q == LMAX);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!i_rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (lock_act) begin
            // bounded lock: let the CPU in once after LMAX locked grants
            if (i_req0 && cnt_hit) gnt0 = 1'b1;
            else                   gnt1 = 1'b1;
        end else if (i_req0 && i_req1) begin
            if (last_q) gnt0 = 1'b1;
            else        gnt1 = 1'b1;
        end else begin
            gnt0 = i_req0;
            gnt1 = i_req1;
        end
    end

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we_h  = 1'b0;
        o_mem_we_l  = 1'b0;
        o_mem_addr  = '0;
        o_mem_din_h = '0;
        o_mem_din_l = '0;
        unique case (1'b1)
            gnt0: begin
                o_mem_en    = 1'b1;
                o_mem_we_h  = i_wr0 & i_be0[1];
                o_mem_we_l  = i_wr0 & i_be0[0];
                o_mem_addr  = i_addr0;
                o_mem_din_h = i_wdata0[15:8];
                o_mem_din_l = i_wdata0[7:0];
            end
            gnt1: begin
                o_mem_en    = 1'b1;
                o_mem_we_h  = i_wr1 & i_be1[1];
                o_mem_we_l  = i_wr1 & i_be1[0];
                o_mem_addr  = i_addr1;
                o_mem_din_h = i_wdata1[15:8];
                o_mem_din_l = i_wdata1[7:0];
            end
            default: begin
                o_mem_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (gnt0) last_d = 1'b0;
        if (gnt1) last_d = 1'b1;

        lock_d = lock_q;
        if (gnt1 && i_lock1) lock_d = 1'b1;
        else if (!lock_act)  lock_d = 1'b0;

        cnt_d = cnt_q;
        if (!lock_d || gnt0)      cnt_d = '0;
        else if (gnt1 && i_req0)  cnt_d = cnt_q + 1'b1;

        rv0_d = gnt0 & ~i_wr0;
        rv1_d = gnt1 & ~i_wr1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_q <= 1'b1;
            lock_q <= 1'b0;
            cnt_q  <= '0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
            rv0_q  <= rv0_d;
            rv1_q  <= rv1_d;
        end
    end

    assign o_gnt0    = gnt0;
    assign o_gnt1    = gnt1;
    assign o_rvalid0 = rv0_q;
    assign o_rvalid1 = rv1_q;
    assign o_rdata   = {i_mem_dout_h, i_mem_dout_l};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural byte RAM.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_ram_port_arbiter;

    logic       i_clk;
    logic       i_rst;
    logic       i_req0, i_req1;
    logic       i_wr0, i_wr1;
    logic [1:0] i_be0, i_be1;
    logic [9:1] i_addr0, i_addr1;
    logic [15:0] i_wdata0, i_wdata1;
    logic       i_lock1;
    logic       o_gnt0, o_gnt1;
    logic       o_rvalid0, o_rvalid1;
    logic [15:0] o_rdata;
    logic       o_mem_en, o_mem_we_h, o_mem_we_l;
    logic [9:1] o_mem_addr;
    logic [7:0] o_mem_din_h, o_mem_din_l;
    logic [7:0] i_mem_dout_h, i_mem_dout_l;

    int checks = 0;
    int errors = 0;

    logic [7:0] mh [0:511];
    logic [7:0] ml [0:511];

    ram_port_arbiter #(.P_LOCK_MAX(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_wr0(i_wr0), .i_wr1(i_wr1),
        .i_be0(i_be0), .i_be1(i_be1),
        .i_addr0(i_addr0), .i_addr1(i_addr1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .i_lock1(i_lock1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
        .o_rdata(o_rdata),
        .o_mem_en(o_mem_en),
        .o_mem_we_h(o_mem_we_h), .o_mem_we_l(o_mem_we_l),
        .o_mem_addr(o_mem_addr),
        .o_mem_din_h(o_mem_din_h), .o_mem_din_l(o_mem_din_l),
        .i_mem_dout_h(i_mem_dout_h), .i_mem_dout_l(i_mem_dout_l)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_mem_en) begin
            if (o_mem_we_h) mh[o_mem_addr] <= o_mem_din_h;
            if (o_mem_we_l) ml[o_mem_addr] <= o_mem_din_l;
            i_mem_dout_h <= mh[o_mem_addr];
            i_mem_dout_l <= ml[o_mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge i_clk);
    endtask

    task automatic drv0(input logic rq, input logic wr,
                        input logic [1:0] be, input logic [9:1] a,
                        input logic [15:0] d);
        i_req0 = rq; i_wr0 = wr; i_be0 = be;
        i_addr0 = a; i_wdata0 = d;
    endtask

    task automatic drv1(input logic rq, input logic wr,
                        input logic [1:0] be, input logic [9:1] a,
                        input logic [15:0] d);
        i_req1 = rq; i_wr1 = wr; i_be1 = be;
        i_addr1 = a; i_wdata1 = d;
    endtask

    task automatic idle();
        drv0(0, 0, 2'b00, 9'd0, 16'h0);
        drv1(0, 0, 2'b00, 9'd0, 16'h0);
        i_lock1 = 1'b0;
    endtask

    task automatic pulse_rst();
        idle();
        i_rst = 1'b0;
        nxt();
        i_rst = 1'b1;
    endtask

    task automatic gnt_pair(input string tag, input logic g0,
                            input logic g1);
        chk({tag, "_g0"}, 32'(o_gnt0), 32'(g0));
        chk({tag, "_g1"}, 32'(o_gnt1), 32'(g1));
    endtask

    initial begin
        idle();
        i_rst = 1'b0;
        nxt();
        // requests during reset must not be granted
        drv0(1, 1, 2'b11, 9'd128, 16'hABCD);
        drv1(1, 0, 2'b00, 9'd5, 16'h0);
        #1;
        gnt_pair("rst", 0, 0);
        chk("rst_en", 32'(o_mem_en), 0);
        chk("rst_weh", 32'(o_mem_we_h), 0);
        chk("rst_addr", 32'(o_mem_addr), 0);
        chk("rst_din", 32'({o_mem_din_h, o_mem_din_l}), 0);
        chk("rst_rv", 32'({o_rvalid0, o_rvalid1}), 0);
        idle();
        nxt();
        i_rst = 1'b1;

        // single write then read at 128
        drv0(1, 1, 2'b11, 9'd128, 16'hABCD);
        #1;
        gnt_pair("wr", 1, 0);
        chk("wr_en", 32'(o_mem_en), 1);
        chk("wr_we", 32'({o_mem_we_h, o_mem_we_l}), 32'h3);
        chk("wr_addr", 32'(o_mem_addr), 128);
        chk("wr_din", 32'({o_mem_din_h, o_mem_din_l}), 32'hABCD);
        nxt();
        drv0(1, 0, 2'b11, 9'd128, 16'h0);
        #1;
        gnt_pair("rd", 1, 0);
        chk("rd_we", 32'({o_mem_we_h, o_mem_we_l}), 0);
        chk("wr_norv", 32'({o_rvalid0, o_rvalid1}), 0);
        nxt();
        idle();
        #1;
        chk("rd_rv0", 32'(o_rvalid0), 1);
        chk("rd_rv1", 32'(o_rvalid1), 0);
        chk("rd_data", 32'(o_rdata), 32'hABCD);
        gnt_pair("idle", 0, 0);
        chk("idle_en", 32'(o_mem_en), 0);
        chk("idle_addr", 32'(o_mem_addr), 0);
        nxt();
        #1;
        chk("rv_once", 32'(o_rvalid0), 0);

        // byte write through port 1
        drv0(1, 1, 2'b11, 9'd5, 16'h1234);
        nxt();
        drv0(0, 0, 2'b00, 9'd0, 16'h0);
        drv1(1, 1, 2'b10, 9'd5, 16'hFF00);
        #1;
        gnt_pair("bw", 0, 1);
        chk("bw_we", 32'({o_mem_we_h, o_mem_we_l}), 32'h2);
        nxt();
        drv1(0, 0, 2'b00, 9'd0, 16'h0);
        drv0(1, 0, 2'b00, 9'd5, 16'h0);
        nxt();
        idle();
        #1;
        chk("bw_rv", 32'(o_rvalid0), 1);
        chk("bw_data", 32'(o_rdata), 32'hFF34);

        // conflict after reset: 0,1,0,1
        nxt();
        pulse_rst();
        drv0(1, 0, 2'b00, 9'd5, 16'h0);
        drv1(1, 0, 2'b00, 9'd128, 16'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            gnt_pair($sformatf("cf%0d", k), k % 2 == 0, k % 2 == 1);
            if (k > 0) begin
                chk($sformatf("cf%0d_rv", k),
                    32'({o_rvalid0, o_rvalid1}),
                    (k % 2 == 1) ? 32'h2 : 32'h1);
                chk($sformatf("cf%0d_rd", k), 32'(o_rdata),
                    (k % 2 == 1) ? 32'hFF34 : 32'hABCD);
            end
            nxt();
        end
        idle();
        #1;
        chk("cf_lastrv", 32'({o_rvalid0, o_rvalid1}), 32'h1);
        chk("cf_lastrd", 32'(o_rdata), 32'hABCD);

        // lock starvation bound: 0, 8x1, 0, 8x1, 0
        nxt();
        pulse_rst();
        drv0(1, 0, 2'b00, 9'd5, 16'h0);
        drv1(1, 0, 2'b00, 9'd128, 16'h0);
        i_lock1 = 1'b1;
        for (int k = 0; k < 19; k++) begin
            #1;
            gnt_pair($sformatf("lk%0d", k), k % 9 == 0, k % 9 != 0);
            nxt();
        end
        // lock dropped: round-robin decides (last was 0)
        i_lock1 = 1'b0;
        #1;
        gnt_pair("unlk0", 0, 1);
        nxt();
        #1;
        gnt_pair("unlk1", 1, 0);
        nxt();

        // counter frozen while the CPU is idle
        pulse_rst();
        drv1(1, 0, 2'b00, 9'd128, 16'h0);
        i_lock1 = 1'b1;
        for (int k = 0; k < 10; k++) nxt();
        drv0(1, 0, 2'b00, 9'd5, 16'h0);
        for (int k = 0; k < 9; k++) begin
            #1;
            gnt_pair($sformatf("lf%0d", k), k == 8, k != 8);
            nxt();
        end

        // reset during a pending read
        idle();
        nxt();
        drv0(1, 0, 2'b00, 9'd5, 16'h0);
        #1;
        gnt_pair("mr", 1, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle();
        nxt();
        #1;
        chk("mr_rv_rst", 32'({o_rvalid0, o_rvalid1}), 0);
        nxt();
        i_rst = 1'b1;
        #1;
        chk("mr_rv_rel", 32'({o_rvalid0, o_rvalid1}), 0);
        nxt();
        drv0(1, 0, 2'b00, 9'd5, 16'h0);
        drv1(1, 0, 2'b00, 9'd128, 16'h0);
        #1;
        gnt_pair("mr_cf", 1, 0);
        chk("mr_rv_late", 32'({o_rvalid0, o_rvalid1}), 0);
        nxt();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter P_LOCK_MAX, default 8, meaning the maximum consecutive locked loader grants while the CPU waits.
REQ-002 SHALL have port i_clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports i_req0 / i_req1  input  1  access request, requester 0 = CPU data port, requester 1 = loader/debug port.
REQ-005 SHALL have ports i_wr0 / i_wr1  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports i_be0 / i_be1  input  2  byte enables; bit1 = high byte, bit0 = low byte; used for writes only.
REQ-007 SHALL have ports i_addr0 / i_addr1  input  9 ([9:1])  word address.
REQ-008 SHALL have ports i_wdata0 / i_wdata1  input  16  write data, [15:8] high byte.
REQ-009 SHALL have port i_lock1  input  1  loader burst-lock request.
REQ-010 SHALL have ports o_gnt0 / o_gnt1  output  1  combinational same-cycle grant.
REQ-011 SHALL have ports o_rvalid0 / o_rvalid1  output  1  registered read-data-valid strobe.
REQ-012 SHALL have port o_rdata  output  16  read data {i_mem_dout_h, i_mem_dout_l}.
REQ-013 SHALL have ports o_mem_en, o_mem_we_h, o_mem_we_l  output  1  RAM enable and byte write strobes.
REQ-014 SHALL have ports o_mem_addr  output  9 ([9:1]), and o_mem_din_h / o_mem_din_l  output  8, driving the RAM port.
REQ-015 SHALL have ports i_mem_dout_h / i_mem_dout_l  input  8  RAM registered read data, valid the cycle after an enabled read.

Function
REQ-016 SHALL grant at most one requester per cycle: o_gnt0 & o_gnt1 is never 1.
REQ-017 SHALL grant the sole requester when only one of i_req0/i_req1 is high.
REQ-018 SHALL, on conflict with no lock active, grant the requester not granted most recently (round-robin pointer, updated on every grant).
REQ-019 SHALL drive o_mem_en=1 and route the winner's address, data and strobes to the RAM in the grant cycle.
REQ-020 SHALL drive o_mem_we_h = winner i_wr & i_be[1] and o_mem_we_l = winner i_wr & i_be[0].
REQ-021 SHALL drive o_mem_en, o_mem_we_h, o_mem_we_l, o_mem_addr and o_mem_din_h/o_mem_din_l all to 0 when there is no grant.
REQ-022 SHALL assert o_rvalidN for exactly one cycle, the cycle after a granted read by requester N.
REQ-023 SHALL not assert o_rvalidN for a granted write.
REQ-024 SHALL present o_rdata as the RAM output unconditionally; it is meaningful only while an o_rvalid is high.
REQ-025 SHALL sustain back-to-back grants, one access per cycle, with o_rvalid pipelined one cycle behind each read grant.
REQ-026 SHALL set the lock-active state when requester 1 is granted with i_lock1=1.
REQ-027 SHALL, while lock-active and i_req1=1, grant requester 1 regardless of the round-robin pointer.
REQ-028 SHALL clear lock-active on the first cycle in which i_lock1=0 or i_req1=0.
REQ-029 SHALL keep a lock counter (width clog2(P_LOCK_MAX+1)) that increments on each locked requester-1 grant while i_req0=1, and clears whenever requester 0 is granted or the lock clears.
REQ-030 SHALL, when the lock counter equals P_LOCK_MAX and i_req0=1, grant requester 0 for one cycle, clear the counter, keep lock-active, and then resume locked grants.
REQ-031 SHALL not increment the lock counter while i_req0=0.
REQ-032 SHALL use the round-robin pointer for the first grant after the lock clears.
REQ-033 SHALL not buffer requests: an ungranted request must be held by the requester until granted.

Reset
REQ-034 SHALL, while i_rst=0, force o_gnt0=o_gnt1=0, o_mem_en=0, both write strobes 0, and o_mem_addr and o_mem_din_h/o_mem_din_l to 0.
REQ-035 SHALL, asynchronously on i_rst=0, clear o_rvalid0/o_rvalid1, lock-active and the lock counter, and set the pointer so requester 0 wins the first conflict.
REQ-036 SHALL discard a read pending when reset asserts mid-access: no o_rvalid follows reset release.

Verification
REQ-037 Single write/read: req0 writes 0xABCD at address 128, be=2'b11, then reads 128 -> gnt0 in both cycles; o_rvalid0 one cycle after the read grant; o_rdata=0xABCD.
REQ-038 Byte write: write 0x1234 at 5, then req1 writes 0xFF00 with be=2'b10, then read 5 -> 0xFF34.
REQ-039 Conflict: both request reads for 4 cycles after reset, no lock -> grants 0,1,0,1; each o_rvalid follows its own grant by one cycle.
REQ-040 Lock starvation: i_lock1=1 and both requesting continuously, P_LOCK_MAX=8 -> 8 gnt1, 1 gnt0, 8 gnt1, and so on.
REQ-041 Reset mid-read: i_rst driven low in the cycle after a read grant -> o_rvalid stays 0; after release, a conflict grants requester 0 first.
